// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the 4-bit load/transfer core:
//                r/q operand codes, opcode field values, the register-file
//                view, the registered write-back plan and pointer helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Register/memory operand code carried in r and q opcode fields
    typedef enum logic [1:0] {
        RQ_A  = 2'd0,
        RQ_B  = 2'd1,
        RQ_MX = 2'd2,
        RQ_MY = 2'd3
    } rq_e;

    // Top opcode nibble (ir[11:8])
    localparam logic [3:0] c_OP_LD_Y_E = 4'h8;
    localparam logic [3:0] c_OP_LBPX   = 4'h9;
    localparam logic [3:0] c_OP_LD_X_E = 4'hB;
    localparam logic [3:0] c_OP_GRP_E  = 4'hE;
    localparam logic [3:0] c_OP_GRP_F  = 4'hF;

    // Second nibble (ir[7:4]) within the E group
    localparam logic [3:0] c_E_LDPX_I  = 4'h6;
    localparam logic [3:0] c_E_LDPY_I  = 4'h7;
    localparam logic [3:0] c_E_LD_X_R  = 4'h8;
    localparam logic [3:0] c_E_LD_Y_R  = 4'h9;
    localparam logic [3:0] c_E_LD_R_X  = 4'hA;
    localparam logic [3:0] c_E_LD_R_Y  = 4'hB;
    localparam logic [3:0] c_E_LD_R_Q  = 4'hC;
    localparam logic [3:0] c_E_LDPX_RQ = 4'hE;
    localparam logic [3:0] c_E_LDPY_RQ = 4'hF;

    // Second nibble (ir[7:4]) within the F group
    localparam logic [3:0] c_F_LD_MI_A = 4'h8;
    localparam logic [3:0] c_F_LD_MI_B = 4'h9;
    localparam logic [3:0] c_F_LD_A_MI = 4'hA;
    localparam logic [3:0] c_F_LD_B_MI = 4'hB;
    localparam logic [3:0] c_F_SPH     = 4'hE;
    localparam logic [3:0] c_F_SPL     = 4'hF;

    typedef struct packed {
        logic [12:0] pc;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  sp;
    } regs_t;

    // Write-back plan built during execute and applied in the last cycle.
    // x_we/y_we bit 2 = P nibble, bit 1 = H nibble, bit 0 = L nibble.
    typedef struct packed {
        logic        a_we;
        logic        b_we;
        logic [2:0]  x_we;
        logic [2:0]  y_we;
        logic [1:0]  sp_we;
        logic [3:0]  a_d;
        logic [3:0]  b_d;
        logic [11:0] x_d;
        logic [11:0] y_d;
        logic [7:0]  sp_d;
        logic        m0_we;
        logic [11:0] m0_addr;
        logic [3:0]  m0_d;
        logic        m1_we;
        logic [11:0] m1_addr;
        logic [3:0]  m1_d;
    } wb_t;

    // Post-increment keeps the page nibble and wraps the low byte
    function automatic logic [11:0] ptr_inc(input logic [11:0] p, input logic [7:0] n);
        return {p[11:8], p[7:0] + n};
    endfunction

    // Nibble select: 0 = P, 1 = H, 2 = L
    function automatic logic [3:0] nib_sel(input logic [11:0] p, input logic [1:0] s);
        case (s)
            2'd0:    return p[11:8];
            2'd1:    return p[7:4];
            2'd2:    return p[3:0];
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [2:0] nib_we(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_regs.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_regs
//  Description : A/B/X/Y/SP/PC storage with per-nibble write enables.
//  Ports       : clk, i_reset_n (sync, active-low); i_*_we / i_*_d write
//                enables and data per register; o_regs current contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_regs
    import cpu_pkg::*;
#(
    parameter logic [12:0] RESET_PC = 13'h0100
)(
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_a_we,
    input  logic [3:0]  i_a_d,
    input  logic        i_b_we,
    input  logic [3:0]  i_b_d,
    input  logic [2:0]  i_x_we,
    input  logic [11:0] i_x_d,
    input  logic [2:0]  i_y_we,
    input  logic [11:0] i_y_d,
    input  logic [1:0]  i_sp_we,
    input  logic [7:0]  i_sp_d,
    input  logic        i_pc_we,
    input  logic [12:0] i_pc_d,
    output regs_t       o_regs
);

    regs_t r_regs;

    assign o_regs = r_regs;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_regs    <= '0;
            r_regs.pc <= RESET_PC;
        end else begin
            if (i_a_we)  r_regs.a  <= i_a_d;
            if (i_b_we)  r_regs.b  <= i_b_d;
            if (i_pc_we) r_regs.pc <= i_pc_d;
            for (int n = 0; n < 3; n++) begin
                if (i_x_we[n]) r_regs.x[n*4 +: 4] <= i_x_d[n*4 +: 4];
                if (i_y_we[n]) r_regs.y[n*4 +: 4] <= i_y_d[n*4 +: 4];
            end
            for (int n = 0; n < 2; n++) begin
                if (i_sp_we[n]) r_regs.sp[n*4 +: 4] <= i_sp_d[n*4 +: 4];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_core_bench.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_core_bench
//  Description : 4-bit load/transfer CPU core with 4096x4 data RAM. Every
//                instruction takes five clocks: fetch, decode, operand read,
//                execute, write back.
//  Ports       : clk, reset_n (sync, active-low); rom_addr/rom_data opcode
//                bus; dbg_we + dbg_a/b/x/y/sp register preload (fetch cycle
//                only); dbg_ram_we/addr/d/q RAM backdoor; pc/a/b/x/y/sp
//                register view; instr_done high in the write-back cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_core_bench
    import cpu_pkg::*;
#(
    parameter logic [12:0] RESET_PC = 13'h0100
)(
    input  logic        clk,
    input  logic        reset_n,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_data,
    input  logic        dbg_we,
    input  logic [3:0]  dbg_a,
    input  logic [3:0]  dbg_b,
    input  logic [11:0] dbg_x,
    input  logic [11:0] dbg_y,
    input  logic [7:0]  dbg_sp,
    input  logic        dbg_ram_we,
    input  logic [11:0] dbg_ram_addr,
    input  logic [3:0]  dbg_ram_d,
    output logic [3:0]  dbg_ram_q,
    output logic [12:0] pc,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [7:0]  sp,
    output logic        instr_done
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_READ   = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;

    logic [2:0]  r_state, w_state_nxt;
    logic        w_ir_load, w_src_load, w_wb_load, w_commit, w_dbg_load, w_instr_done;
    logic [11:0] r_ir;
    logic [3:0]  r_src, w_src, w_rq_lo, w_mx, w_my, w_mi;
    wb_t         r_wb, w_wb;
    logic        w_rd_en;
    logic [1:0]  w_rd;
    regs_t       w_regs;
    logic        w_a_we, w_b_we, w_pc_we;
    logic [3:0]  w_a_d, w_b_d;
    logic [2:0]  w_x_we, w_y_we;
    logic [11:0] w_x_d, w_y_d;
    logic [1:0]  w_sp_we;
    logic [7:0]  w_sp_d;
    logic [12:0] w_pc_d;
    logic [3:0]  r_mem [0:4095];

    // ---------------- cycle sequencer ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= c_ST_FETCH;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        case (r_state)
            c_ST_FETCH:  w_state_nxt = c_ST_DECODE;
            c_ST_DECODE: w_state_nxt = c_ST_READ;
            c_ST_READ:   w_state_nxt = c_ST_EXEC;
            c_ST_EXEC:   w_state_nxt = c_ST_WB;
            default:     w_state_nxt = c_ST_FETCH;
        endcase
    end

    always_comb begin
        w_ir_load    = 1'b0;
        w_dbg_load   = 1'b0;
        w_src_load   = 1'b0;
        w_wb_load    = 1'b0;
        w_commit     = 1'b0;
        w_instr_done = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                w_ir_load  = 1'b1;
                w_dbg_load = dbg_we;
            end
            c_ST_READ:  w_src_load = 1'b1;
            c_ST_EXEC:  w_wb_load  = 1'b1;
            c_ST_WB: begin
                w_commit     = 1'b1;
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ir  <= '0;
            r_src <= '0;
            r_wb  <= '0;
        end else begin
            if (w_ir_load)  r_ir  <= rom_data;
            if (w_src_load) r_src <= w_src;
            if (w_wb_load)  r_wb  <= w_wb;
        end
    end

    // ---------------- operand read ----------------
    assign w_mx = r_mem[w_regs.x];
    assign w_my = r_mem[w_regs.y];
    assign w_mi = r_mem[{8'h00, r_ir[3:0]}];

    // ir[1:0] is the only register-coded source field used by this subset
    always_comb begin
        case (r_ir[1:0])
            RQ_A:    w_rq_lo = w_regs.a;
            RQ_B:    w_rq_lo = w_regs.b;
            RQ_MX:   w_rq_lo = w_mx;
            default: w_rq_lo = w_my;
        endcase
    end

    always_comb begin
        w_src = r_ir[3:0];                      // immediate unless overridden
        case (r_ir[11:8])
            c_OP_GRP_E: case (r_ir[7:4])
                c_E_LD_X_R, c_E_LD_Y_R, c_E_LD_R_Q,
                c_E_LDPX_RQ, c_E_LDPY_RQ: w_src = w_rq_lo;
                c_E_LD_R_X:               w_src = nib_sel(w_regs.x, r_ir[3:2]);
                c_E_LD_R_Y:               w_src = nib_sel(w_regs.y, r_ir[3:2]);
                default: ;
            endcase
            c_OP_GRP_F: case (r_ir[7:4])
                c_F_LD_MI_A:              w_src = w_regs.a;
                c_F_LD_MI_B:              w_src = w_regs.b;
                c_F_LD_A_MI, c_F_LD_B_MI: w_src = w_mi;
                c_F_SPH:                  w_src = r_ir[2] ? w_regs.sp[7:4] : w_rq_lo;
                c_F_SPL:                  w_src = r_ir[2] ? w_regs.sp[3:0] : w_rq_lo;
                default: ;
            endcase
            default: ;
        endcase
    end

    // ---------------- execute: build the write-back plan ----------------
    always_comb begin
        w_wb      = '0;
        w_wb.x_d  = w_regs.x;
        w_wb.y_d  = w_regs.y;
        w_wb.sp_d = w_regs.sp;
        w_rd_en   = 1'b0;
        w_rd      = r_ir[1:0];
        case (r_ir[11:8])
            c_OP_LD_X_E: begin
                w_wb.x_we = 3'b011;
                w_wb.x_d  = {w_regs.x[11:8], r_ir[7:0]};
            end
            c_OP_LD_Y_E: begin
                w_wb.y_we = 3'b011;
                w_wb.y_d  = {w_regs.y[11:8], r_ir[7:0]};
            end
            c_OP_LBPX: begin
                w_wb.m0_we   = 1'b1;
                w_wb.m0_addr = w_regs.x;
                w_wb.m0_d    = r_ir[3:0];
                w_wb.m1_we   = 1'b1;
                w_wb.m1_addr = ptr_inc(w_regs.x, 8'd1);
                w_wb.m1_d    = r_ir[7:4];
                w_wb.x_we    = 3'b011;
                w_wb.x_d     = ptr_inc(w_regs.x, 8'd2);
            end
            c_OP_GRP_E: case (r_ir[7:4])
                4'h0, 4'h1, 4'h2, 4'h3: begin
                    w_rd_en = 1'b1;
                    w_rd    = r_ir[5:4];
                end
                c_E_LDPX_I: begin
                    w_rd_en   = 1'b1;
                    w_rd      = RQ_MX;
                    w_wb.x_we = 3'b011;
                    w_wb.x_d  = ptr_inc(w_regs.x, 8'd1);
                end
                c_E_LDPY_I: begin
                    w_rd_en   = 1'b1;
                    w_rd      = RQ_MY;
                    w_wb.y_we = 3'b011;
                    w_wb.y_d  = ptr_inc(w_regs.y, 8'd1);
                end
                c_E_LD_X_R: begin
                    w_wb.x_we = nib_we(r_ir[3:2]);
                    w_wb.x_d  = {r_src, r_src, r_src};
                end
                c_E_LD_Y_R: begin
                    w_wb.y_we = nib_we(r_ir[3:2]);
                    w_wb.y_d  = {r_src, r_src, r_src};
                end
                c_E_LD_R_X, c_E_LD_R_Y: w_rd_en = (r_ir[3:2] != 2'b11);
                c_E_LD_R_Q: begin
                    w_rd_en = 1'b1;
                    w_rd    = r_ir[3:2];
                end
                c_E_LDPX_RQ: begin
                    w_rd_en   = 1'b1;
                    w_rd      = r_ir[3:2];
                    w_wb.x_we = 3'b011;
                    w_wb.x_d  = ptr_inc(w_regs.x, 8'd1);
                end
                c_E_LDPY_RQ: begin
                    w_rd_en   = 1'b1;
                    w_rd      = r_ir[3:2];
                    w_wb.y_we = 3'b011;
                    w_wb.y_d  = ptr_inc(w_regs.y, 8'd1);
                end
                default: ;
            endcase
            c_OP_GRP_F: case (r_ir[7:4])
                c_F_LD_MI_A, c_F_LD_MI_B: begin
                    w_wb.m0_we   = 1'b1;
                    w_wb.m0_addr = {8'h00, r_ir[3:0]};
                    w_wb.m0_d    = r_src;
                end
                c_F_LD_A_MI: begin
                    w_rd_en = 1'b1;
                    w_rd    = RQ_A;
                end
                c_F_LD_B_MI: begin
                    w_rd_en = 1'b1;
                    w_rd    = RQ_B;
                end
                c_F_SPH, c_F_SPL: begin
                    if (r_ir[3:2] == 2'b00) begin
                        w_wb.sp_we = r_ir[4] ? 2'b01 : 2'b10;
                        w_wb.sp_d  = {r_src, r_src};
                    end
                    w_rd_en = (r_ir[3:2] == 2'b01);
                end
                default: ;
            endcase
            default: ;
        endcase

        // Destination register code; memory targets use pre-increment X/Y
        if (w_rd_en) begin
            case (w_rd)
                RQ_A: begin
                    w_wb.a_we = 1'b1;
                    w_wb.a_d  = r_src;
                end
                RQ_B: begin
                    w_wb.b_we = 1'b1;
                    w_wb.b_d  = r_src;
                end
                RQ_MX: begin
                    w_wb.m0_we   = 1'b1;
                    w_wb.m0_addr = w_regs.x;
                    w_wb.m0_d    = r_src;
                end
                default: begin
                    w_wb.m0_we   = 1'b1;
                    w_wb.m0_addr = w_regs.y;
                    w_wb.m0_d    = r_src;
                end
            endcase
        end
    end

    // ---------------- register file ----------------
    always_comb begin
        w_a_we  = 1'b0;
        w_b_we  = 1'b0;
        w_x_we  = 3'b000;
        w_y_we  = 3'b000;
        w_sp_we = 2'b00;
        w_pc_we = 1'b0;
        w_a_d   = w_dbg_load ? dbg_a  : r_wb.a_d;
        w_b_d   = w_dbg_load ? dbg_b  : r_wb.b_d;
        w_x_d   = w_dbg_load ? dbg_x  : r_wb.x_d;
        w_y_d   = w_dbg_load ? dbg_y  : r_wb.y_d;
        w_sp_d  = w_dbg_load ? dbg_sp : r_wb.sp_d;
        w_pc_d  = {w_regs.pc[12:8], w_regs.pc[7:0] + 8'd1};
        if (w_dbg_load) begin
            w_a_we  = 1'b1;
            w_b_we  = 1'b1;
            w_x_we  = 3'b111;
            w_y_we  = 3'b111;
            w_sp_we = 2'b11;
        end else if (w_commit) begin
            w_a_we  = r_wb.a_we;
            w_b_we  = r_wb.b_we;
            w_x_we  = r_wb.x_we;
            w_y_we  = r_wb.y_we;
            w_sp_we = r_wb.sp_we;
            w_pc_we = 1'b1;
        end
    end

    cpu_regs #(
        .RESET_PC (RESET_PC)
    ) u_regs (
        .clk       (clk),
        .i_reset_n (reset_n),
        .i_a_we    (w_a_we),
        .i_a_d     (w_a_d),
        .i_b_we    (w_b_we),
        .i_b_d     (w_b_d),
        .i_x_we    (w_x_we),
        .i_x_d     (w_x_d),
        .i_y_we    (w_y_we),
        .i_y_d     (w_y_d),
        .i_sp_we   (w_sp_we),
        .i_sp_d    (w_sp_d),
        .i_pc_we   (w_pc_we),
        .i_pc_d    (w_pc_d),
        .o_regs    (w_regs)
    );

    // ---------------- data RAM ----------------
    // Core writes come last so they override a same-address backdoor write.
    always_ff @(posedge clk) begin
        if (dbg_ram_we) r_mem[dbg_ram_addr] <= dbg_ram_d;
        if (w_commit && reset_n) begin
            if (r_wb.m0_we) r_mem[r_wb.m0_addr] <= r_wb.m0_d;
            if (r_wb.m1_we) r_mem[r_wb.m1_addr] <= r_wb.m1_d;
        end
    end

    assign dbg_ram_q  = r_mem[dbg_ram_addr];
    assign rom_addr   = w_regs.pc;
    assign pc         = w_regs.pc;
    assign a          = w_regs.a;
    assign b          = w_regs.b;
    assign x          = w_regs.x;
    assign y          = w_regs.y;
    assign sp         = w_regs.sp;
    assign instr_done = w_instr_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_bench.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_core_bench
//  Description : Directed self-checking bench for cpu_core_bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_core_bench;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic        dbg_we;
    logic [3:0]  dbg_a, dbg_b;
    logic [11:0] dbg_x, dbg_y;
    logic [7:0]  dbg_sp;
    logic        dbg_ram_we;
    logic [11:0] dbg_ram_addr;
    logic [3:0]  dbg_ram_d, dbg_ram_q;
    logic [12:0] pc;
    logic [3:0]  a, b;
    logic [11:0] x, y;
    logic [7:0]  sp;
    logic        instr_done;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_core_bench #(.RESET_PC(13'h0100)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .dbg_we       (dbg_we),
        .dbg_a        (dbg_a),
        .dbg_b        (dbg_b),
        .dbg_x        (dbg_x),
        .dbg_y        (dbg_y),
        .dbg_sp       (dbg_sp),
        .dbg_ram_we   (dbg_ram_we),
        .dbg_ram_addr (dbg_ram_addr),
        .dbg_ram_d    (dbg_ram_d),
        .dbg_ram_q    (dbg_ram_q),
        .pc           (pc),
        .a            (a),
        .b            (b),
        .x            (x),
        .y            (y),
        .sp           (sp),
        .instr_done   (instr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks below start and end #1 after a rising edge with the core in fetch.
    task automatic reset_dut();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Backdoor RAM write while holding the core in reset
    task automatic ram_wr(input logic [11:0] ad, input logic [3:0] d);
        reset_n      = 1'b0;
        dbg_ram_we   = 1'b1;
        dbg_ram_addr = ad;
        dbg_ram_d    = d;
        @(posedge clk);
        #1;
        dbg_ram_we = 1'b0;
        reset_n    = 1'b1;
    endtask

    task automatic ram_chk(input string tag, input logic [11:0] ad, input logic [3:0] exp);
        dbg_ram_addr = ad;
        #1;
        check(tag, dbg_ram_q, exp);
    endtask

    task automatic preload(input logic [3:0] pa, input logic [3:0] pb,
                           input logic [11:0] px, input logic [11:0] py, input logic [7:0] psp);
        dbg_we = 1'b1;
        dbg_a  = pa;
        dbg_b  = pb;
        dbg_x  = px;
        dbg_y  = py;
        dbg_sp = psp;
    endtask

    // One full instruction; optional backdoor write in the write-back cycle
    task automatic exec(input logic [11:0] op, input bit coll,
                        input logic [11:0] cad, input logic [3:0] cd);
        int n;
        rom_data = op;
        @(posedge clk);
        #1;
        dbg_we = 1'b0;
        n = 1;
        while (!instr_done && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 4);
        if (coll) begin
            dbg_ram_we   = 1'b1;
            dbg_ram_addr = cad;
            dbg_ram_d    = cd;
        end
        @(posedge clk);
        #1;
        dbg_ram_we = 1'b0;
    endtask

    task automatic run(input logic [11:0] op);
        exec(op, 1'b0, 12'h000, 4'h0);
    endtask

    logic [11:0] ee_op  [4] = '{12'hEE1, 12'hEE6, 12'hEEB, 12'hEEC};
    logic [3:0]  ee_exp [4] = '{4'h5, 4'hA, 4'hF, 4'h0};

    initial begin
        reset_n = 1'b0; rom_data = '0; dbg_we = 1'b0;
        dbg_a = '0; dbg_b = '0; dbg_x = '0; dbg_y = '0; dbg_sp = '0;
        dbg_ram_we = 1'b0; dbg_ram_addr = '0; dbg_ram_d = '0;
        reset_dut();

        check("rst pc", pc, 13'h0100);
        check("rst rom_addr", rom_addr, 13'h0100);
        check("rst a", a, 0);
        check("rst b", b, 0);
        check("rst x", x, 0);
        check("rst y", y, 0);
        check("rst sp", sp, 0);
        check("rst done", instr_done, 0);

        // LD X,e / LD Y,e
        preload(4'h0, 4'h0, 12'h2AB, 12'h5CC, 8'h00);
        run(12'hB69);
        check("B69 x", x, 12'h269);
        check("B69 pc", pc, 13'h0101);
        check("B69 done low", instr_done, 0);
        preload(4'h0, 4'h0, 12'h2AB, 12'h5CC, 8'h00);
        run(12'h83E);
        check("83E y", y, 12'h53E);
        check("83E x", x, 12'h2AB);

        // LBPX MX,e
        preload(4'h0, 4'h0, 12'h010, 12'h000, 8'h00);
        run(12'h94B);
        ram_chk("94B m010", 12'h010, 4'hB);
        ram_chk("94B m011", 12'h011, 4'h4);
        check("94B x", x, 12'h012);

        // LD r,XH for each destination
        for (int r = 0; r < 4; r++) begin
            ram_wr(12'hACF, 4'h0);
            ram_wr(12'h48E, 4'h0);
            preload(4'h1, 4'h2, 12'hACF, 12'h48E, 8'h00);
            run(12'hEA4 + 12'(r));
            check("EA4 a", a, (r == 0) ? 4'hC : 4'h1);
            check("EA4 b", b, (r == 1) ? 4'hC : 4'h2);
            ram_chk("EA4 mx", 12'hACF, (r == 2) ? 4'hC : 4'h0);
            ram_chk("EA4 my", 12'h48E, (r == 3) ? 4'hC : 4'h0);
        end

        // LDPX r,q with page-preserving X wrap
        for (int k = 0; k < 4; k++) begin
            ram_wr(12'h3FF, 4'hA);
            ram_wr(12'h123, 4'hF);
            preload(4'h0, 4'h5, 12'h3FF, 12'h123, 8'h00);
            run(ee_op[k]);
            case (k)
                0:       check("EE dest a", a, ee_exp[k]);
                1:       check("EE dest b", b, ee_exp[k]);
                2:       ram_chk("EE dest mx", 12'h3FF, ee_exp[k]);
                default: ram_chk("EE dest my", 12'h123, ee_exp[k]);
            endcase
            check("EE x", x, 12'h300);
            check("EE y", y, 12'h123);
        end
        ram_wr(12'h3FF, 4'hA);
        preload(4'h0, 4'h5, 12'h3FF, 12'h123, 8'h00);
        run(12'hEF9);
        ram_chk("EF9 mx", 12'h3FF, 4'h5);
        check("EF9 y", y, 12'h124);
        check("EF9 x", x, 12'h3FF);

        // Page-0 memory direct loads/stores
        for (int j = 0; j < 16; j++) ram_wr(12'(j), 4'(j + 2));
        run(12'hFA7);
        check("FA7 a", a, 4'h9);
        run(12'hFB0);
        check("FB0 b", b, 4'h2);
        preload(4'h5, 4'hC, 12'h000, 12'h000, 8'h00);
        exec(12'hF83, 1'b1, 12'h003, 4'hE);
        ram_chk("F83 m3 core wins", 12'h003, 4'h5);
        run(12'hF9F);
        ram_chk("F9F mf", 12'h00F, 4'hC);

        // Stack pointer nibbles
        preload(4'h0, 4'h7, 12'h000, 12'h000, 8'hB4);
        run(12'hFE4);
        check("FE4 a", a, 4'hB);
        run(12'hFF1);
        check("FF1 sp", sp, 8'hB7);
        run(12'hFF4);
        check("FF4 a", a, 4'h7);
        run(12'hFE1);
        check("FE1 sp", sp, 8'h77);

        // Pointer nibble transfers and immediate stores
        preload(4'h6, 4'h9, 12'h123, 12'h4E2, 8'h00);
        run(12'hE81);
        check("E81 x", x, 12'h923);
        run(12'hE98);
        check("E98 y", y, 12'h4E6);
        run(12'hEB5);
        check("EB5 b", b, 4'hE);
        preload(4'h0, 4'h0, 12'h0FE, 12'h2FF, 8'h00);
        run(12'hE75);
        ram_chk("E75 m2ff", 12'h2FF, 4'h5);
        check("E75 y", y, 12'h200);
        run(12'hE6C);
        ram_chk("E6C m0fe", 12'h0FE, 4'hC);
        check("E6C x", x, 12'h0FF);
        run(12'hE25);
        ram_chk("E25 mx", 12'h0FF, 4'h5);
        run(12'hE1A);
        check("E1A b", b, 4'hA);

        // Reset during write-back aborts the memory write
        preload(4'h3, 4'h0, 12'h050, 12'h000, 8'h00);
        rom_data = 12'hE65;
        @(posedge clk);
        #1 dbg_we = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("abort in wb", instr_done, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        ram_chk("abort m050", 12'h050, 4'h0);
        check("abort pc", pc, 13'h0100);
        check("abort x", x, 12'h000);

        // NOPs and PC wrap within the page
        reset_dut();
        run(12'hE40);
        check("NOP pc", pc, 13'h0101);
        check("NOP a", a, 4'h0);
        for (int i = 0; i < 254; i++) run(12'h000);
        check("pc 1FF", pc, 13'h01FF);
        run(12'h000);
        check("pc wrap", pc, 13'h0100);
        check("NOP x", x, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
